// File: rtl/alt_seq_serializer_pkg.sv
// alt_seq_serializer_pkg: shared state type and framing constants for the serializer and checker
package alt_seq_serializer_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  // Each serial bit occupies this many clock cycles; the checker samples at the same spacing.
  localparam int HOLD_CYCLES = 2;

  localparam logic IDLE_BIT_DEF = 1'b0;

endpackage

// File: rtl/alt_seq_serializer.sv
// alt_seq_serializer: LSB-first serializer holding each bit for two cycles with gapless back-to-back words
module alt_seq_serializer
  import alt_seq_serializer_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = IDLE_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser,
  output logic             busy,
  output logic             bit_first,
  output logic             done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  state_e          state_q;
  logic [WIDTH-1:0] sr_q;
  logic [IW-1:0]   idx_q;
  logic            hold_q;
  logic            done_q;
  logic            last_bit;
  logic            accept;

  assign last_bit   = (state_q == SHIFT) && (idx_q == LAST) && hold_q;
  assign load_ready = (state_q == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;
  assign ser        = (state_q == SHIFT) ? sr_q[0] : IDLE_BIT;
  assign busy       = (state_q == SHIFT);
  assign bit_first  = (state_q == SHIFT) && !hold_q;
  assign done       = done_q;

  // FSM with shift register, bit index and hold flag; a final-bit accept reloads without leaving SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_bit;
      if (accept) begin
        sr_q    <= load_data;
        idx_q   <= '0;
        hold_q  <= 1'b0;
        state_q <= SHIFT;
      end else if (state_q == SHIFT) begin
        if (!hold_q) begin
          hold_q <= 1'b1;
        end else if (last_bit) begin
          state_q <= IDLE;
        end else begin
          sr_q   <= sr_q >> 1;
          idx_q  <= idx_q + 1'b1;
          hold_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alt_seq_serializer.sv
// tb_alt_seq_serializer: randomized and directed checks against a word-timeline reference model
module tb_alt_seq_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         lv = 1'b0;
  logic [W-1:0] ld = '0;
  logic         ready, ser, busy, bf, done;

  logic         lv2 = 1'b0;
  logic [1:0]   ld2 = '0;
  logic         ready2, ser2, busy2, bf2, done2;

  int n_tests = 0;
  int n_fail  = 0;

  // model: edge count, start edge of the word in flight, its data, start edges awaiting done
  int           e = 0;
  int           k = -1;
  logic [W-1:0] w = '0;
  int           starts[$];

  always #5 clk = ~clk;

  alt_seq_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(lv), .load_ready(ready), .load_data(ld),
    .ser(ser), .busy(busy), .bit_first(bf), .done(done)
  );

  alt_seq_serializer #(.WIDTH(2), .IDLE_BIT(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv2), .load_ready(ready2), .load_data(ld2),
    .ser(ser2), .busy(busy2), .bit_first(bf2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // one cycle: check outputs against the timeline, then offer (v,d) at the coming edge
  task automatic step(input logic v, input logic [W-1:0] d);
    int  off;
    bit  act, exp_done, acc;
    @(negedge clk);
    off = e - k;
    act = (k >= 0) && (off < 2 * W);
    exp_done = 1'b0;
    foreach (starts[i]) if (starts[i] + 2 * W == e) exp_done = 1'b1;
    while (starts.size() > 0 && starts[0] + 2 * W < e) void'(starts.pop_front());
    check("ser",       32'(ser),   act ? 32'(w[off / 2]) : 32'(0));
    check("busy",      32'(busy),  32'(act));
    check("bit_first", 32'(bf),    32'(act && (off % 2 == 0)));
    check("done",      32'(done),  32'(exp_done));
    check("ready",     32'(ready), 32'(!act || off == 2 * W - 1));
    acc = v && (!act || off == 2 * W - 1);
    lv = v;
    ld = d;
    @(posedge clk);
    e++;
    if (acc) begin
      k = e;
      w = d;
      starts.push_back(e);
    end
  endtask

  // asynchronous reset mid-cycle: outputs must collapse before any clock edge
  task automatic do_reset();
    @(negedge clk);
    lv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ser",   32'(ser),   32'(0));
    check("rst_busy",  32'(busy),  32'(0));
    check("rst_ready", 32'(ready), 32'(1));
    check("rst_done",  32'(done),  32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold_done", 32'(done), 32'(0));
    rst_n = 1'b1;
    k = -1;
    starts.delete();
  endtask

  initial begin
    logic [3:0] pat2;
    #1;
    check("init_ser",   32'(ser),   32'(0));
    check("init_busy",  32'(busy),  32'(0));
    check("init_bf",    32'(bf),    32'(0));
    check("init_done",  32'(done),  32'(0));
    check("init_ready", 32'(ready), 32'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 8'h55);
    repeat (20) step(1'b0, '0);
    step(1'b1, 8'hFF);
    repeat (18) step(1'b0, '0);
    step(1'b1, 8'h55);
    repeat (15) step(1'b1, 8'hAA);
    repeat (20) step(1'b0, '0);
    step(1'b1, 8'h33);
    repeat (5) step(1'b0, '0);
    step(1'b1, 8'h0F);
    repeat (12) step(1'b0, '0);
    step(1'b1, 8'hC3);
    repeat (4) step(1'b0, '0);
    do_reset();
    step(1'b1, 8'hA5);
    repeat (18) step(1'b0, '0);

    repeat (800) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step($urandom_range(0, 2) == 0, W'($urandom));
    end
    repeat (20) step(1'b0, '0);

    pat2 = 4'b1100;
    @(negedge clk);
    check("w2_ready", 32'(ready2), 32'(1));
    lv2 = 1'b1;
    ld2 = 2'b10;
    @(negedge clk);
    lv2 = 1'b0;
    ld2 = 2'b01;
    for (int i = 0; i < 4; i++) begin
      check("w2_ser",  32'(ser2),  32'(pat2[i]));
      check("w2_busy", 32'(busy2), 32'(1));
      check("w2_bf",   32'(bf2),   32'(i % 2 == 0));
      check("w2_done", 32'(done2), 32'(0));
      @(negedge clk);
    end
    check("w2_done_pulse", 32'(done2), 32'(1));
    check("w2_idle",       32'(busy2), 32'(0));
    @(negedge clk);
    check("w2_done_clear", 32'(done2), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
